// File: rtl/core_regfile_pkg.sv
// Shared widths, types and index helpers for the integer register file and its scoreboard.
`ifndef CPU_RFIDX_WIDTH
`define CPU_RFIDX_WIDTH 5
`endif
`ifndef OPERAND_WIDTH
`define OPERAND_WIDTH 64
`endif
`ifndef CPU_RF_NUM
`define CPU_RF_NUM 32
`endif

package core_regfile_pkg;

  typedef logic [`CPU_RFIDX_WIDTH-1:0] rfidx_t;
  typedef logic [`OPERAND_WIDTH-1:0]   operand_t;

  typedef struct packed {
    logic     vld;
    rfidx_t   idx;
    operand_t data;
  } wb_req_t;

  // x0 and anything beyond the implemented depth behave as the hardwired zero register.
  function automatic logic idx_live(input rfidx_t idx, input int unsigned depth);
    return (idx != '0) && (32'(idx) < depth);
  endfunction

endpackage

// File: rtl/core_scoreboard.sv
// Pending-write tracker: one busy bit per register, set at issue, cleared at write-back.
module core_scoreboard
  import core_regfile_pkg::*;
#(
  parameter int unsigned RF_DEPTH = `CPU_RF_NUM
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   set_vld_i,
  input  rfidx_t set_idx_i,
  input  logic   clr_vld_i,
  input  rfidx_t clr_idx_i,
  input  logic   flush_i,
  input  rfidx_t rs1_idx_i,
  input  rfidx_t rs2_idx_i,
  output logic   rs1_busy_o,
  output logic   rs2_busy_o
);

  logic [RF_DEPTH-1:0] r_busy;
  logic [RF_DEPTH-1:0] w_busy_nxt;

  // Order matters: clear, then set (newer producer wins), then flush over everything.
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_vld_i && idx_live(clr_idx_i, RF_DEPTH)) w_busy_nxt[clr_idx_i] = 1'b0;
    if (set_vld_i && idx_live(set_idx_i, RF_DEPTH)) w_busy_nxt[set_idx_i] = 1'b1;
    if (flush_i) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign rs1_busy_o = idx_live(rs1_idx_i, RF_DEPTH) && r_busy[rs1_idx_i];
  assign rs2_busy_o = idx_live(rs2_idx_i, RF_DEPTH) && r_busy[rs2_idx_i];

endmodule

// File: rtl/core_regfile.sv
// Two-read / one-write integer register file with optional write-back forwarding
// and a per-register pending-write scoreboard.
module core_regfile
  import core_regfile_pkg::*;
#(
  parameter int unsigned RF_DEPTH  = `CPU_RF_NUM,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rsd_wen_i,
  input  logic [`CPU_RFIDX_WIDTH-1:0] rsd_idx_i,
  input  logic [`OPERAND_WIDTH-1:0]   rsd_data_i,
  input  logic [`CPU_RFIDX_WIDTH-1:0] rs1_idx_i,
  input  logic [`CPU_RFIDX_WIDTH-1:0] rs2_idx_i,
  output logic [`OPERAND_WIDTH-1:0]   rs1_data_o,
  output logic [`OPERAND_WIDTH-1:0]   rs2_data_o,
  input  logic                        issue_vld_i,
  input  logic [`CPU_RFIDX_WIDTH-1:0] issue_rd_i,
  input  logic                        flush_i,
  output logic                        rs1_busy_o,
  output logic                        rs2_busy_o
);

  wb_req_t  w_wb;
  logic     w_wr_ok;
  operand_t r_rf [RF_DEPTH];

  rfidx_t   w_rd_idx  [2];
  operand_t w_rd_data [2];
  logic     w_sb_busy [2];
  logic     w_rd_busy [2];
  logic     w_hit     [2];

  assign w_wb    = '{vld: rsd_wen_i, idx: rsd_idx_i, data: rsd_data_i};
  assign w_wr_ok = w_wb.vld && idx_live(w_wb.idx, RF_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RF_DEPTH); i++) r_rf[i] <= '0;
    end else if (w_wr_ok) begin
      r_rf[w_wb.idx] <= w_wb.data;
    end
  end

  core_scoreboard #(
    .RF_DEPTH (RF_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_vld_i  (issue_vld_i),
    .set_idx_i  (issue_rd_i),
    .clr_vld_i  (rsd_wen_i),
    .clr_idx_i  (rsd_idx_i),
    .flush_i    (flush_i),
    .rs1_idx_i  (rs1_idx_i),
    .rs2_idx_i  (rs2_idx_i),
    .rs1_busy_o (w_sb_busy[0]),
    .rs2_busy_o (w_sb_busy[1])
  );

  assign w_rd_idx[0] = rs1_idx_i;
  assign w_rd_idx[1] = rs2_idx_i;

  // Forwarding is gated by rst_n so outputs read zero for the whole reset window.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_hit[p]     = BYPASS_EN && rst_n && w_wr_ok && (w_wb.idx == w_rd_idx[p]);
      w_rd_data[p] = '0;
      if (w_hit[p])                              w_rd_data[p] = w_wb.data;
      else if (idx_live(w_rd_idx[p], RF_DEPTH))  w_rd_data[p] = r_rf[w_rd_idx[p]];
      w_rd_busy[p] = rst_n && w_sb_busy[p] && !w_hit[p];
    end
  end

  assign rs1_data_o = w_rd_data[0];
  assign rs2_data_o = w_rd_data[1];
  assign rs1_busy_o = w_rd_busy[0];
  assign rs2_busy_o = w_rd_busy[1];

endmodule

// File: tb/tb_core_regfile.sv
// Vector-table bench for core_regfile with a forwarding and a non-forwarding instance.
module tb_core_regfile;
  import core_regfile_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     rsd_wen = 1'b0;
  rfidx_t   rsd_idx = '0;
  operand_t rsd_data = '0;
  rfidx_t   rs1_idx = '0, rs2_idx = '0;
  logic     issue_vld = 1'b0;
  rfidx_t   issue_rd = '0;
  logic     flush = 1'b0;

  operand_t rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
  logic     rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  core_regfile #(.RF_DEPTH(32), .BYPASS_EN(1'b1)) u_rf (
    .clk(clk), .rst_n(rst_n), .rsd_wen_i(rsd_wen), .rsd_idx_i(rsd_idx), .rsd_data_i(rsd_data),
    .rs1_idx_i(rs1_idx), .rs2_idx_i(rs2_idx), .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
    .issue_vld_i(issue_vld), .issue_rd_i(issue_rd), .flush_i(flush),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy)
  );

  core_regfile #(.RF_DEPTH(32), .BYPASS_EN(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rsd_wen_i(rsd_wen), .rsd_idx_i(rsd_idx), .rsd_data_i(rsd_data),
    .rs1_idx_i(rs1_idx), .rs2_idx_i(rs2_idx), .rs1_data_o(nb_rs1_data), .rs2_data_o(nb_rs2_data),
    .issue_vld_i(issue_vld), .issue_rd_i(issue_rd), .flush_i(flush),
    .rs1_busy_o(nb_rs1_busy), .rs2_busy_o(nb_rs2_busy)
  );

  typedef struct {
    logic     wen;  rfidx_t widx; operand_t wdata;
    rfidx_t   r1;   rfidx_t r2;
    logic     iss;  rfidx_t ird;  logic fl;
    operand_t ed1;  operand_t ed2; logic eb1; logic eb2;
  } vec_t;

  typedef struct {
    int       id;
    operand_t ed1; operand_t ed2; logic eb1; logic eb2;
  } exp_t;

  vec_t vt[$];
  exp_t sbq[$];

  function automatic vec_t mk(logic wen, rfidx_t widx, operand_t wdata, rfidx_t r1, rfidx_t r2,
                              logic iss, rfidx_t ird, logic fl,
                              operand_t ed1, operand_t ed2, logic eb1, logic eb2);
    vec_t v;
    v.wen = wen; v.widx = widx; v.wdata = wdata; v.r1 = r1; v.r2 = r2;
    v.iss = iss; v.ird = ird; v.fl = fl;
    v.ed1 = ed1; v.ed2 = ed2; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic idle();
    rsd_wen = 1'b0; rsd_idx = '0; rsd_data = '0;
    issue_vld = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  localparam operand_t D5 = 64'h1122334455667788;
  localparam operand_t F1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    exp_t e;

    // Writes and issue presented while reset is held must be dropped.
    @(negedge clk);
    rsd_wen = 1'b1; rsd_idx = 5'd6; rsd_data = 64'hDEAD;
    issue_vld = 1'b1; issue_rd = 5'd6;
    rs1_idx = 5'd6; rs2_idx = 5'd6;
    #2;
    chk("rst_rs1_data", rs1_data, 64'd0);
    chk("rst_rs2_data", rs2_data, 64'd0);
    chk("rst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    chk("rst_rs2_busy", {63'd0, rs2_busy}, 64'd0);

    //        wen  widx  wdata     r1     r2     iss  ird    fl    ed1    ed2    eb1 eb2
    vt.push_back(mk(1, 5'd5,  D5,      5'd0,  5'd5,  0, 5'd0,  0,  64'd0, D5,    0, 0)); // 0
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd5,  5'd6,  0, 5'd0,  0,  D5,    64'd0, 0, 0)); // 1
    vt.push_back(mk(1, 5'd0,  F1,      5'd0,  5'd0,  1, 5'd0,  0,  64'd0, 64'd0, 0, 0)); // 2
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd0,  5'd0,  0, 5'd0,  0,  64'd0, 64'd0, 0, 0)); // 3
    vt.push_back(mk(1, 5'd7,  64'hA5,  5'd5,  5'd7,  0, 5'd0,  0,  D5,    64'hA5,0, 0)); // 4
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd7,  5'd7,  0, 5'd0,  0,  64'hA5,64'hA5,0, 0)); // 5
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd3,  5'd7,  1, 5'd3,  0,  64'd0, 64'hA5,0, 0)); // 6
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd3,  5'd3,  0, 5'd0,  0,  64'd0, 64'd0, 1, 1)); // 7
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd3,  5'd0,  0, 5'd0,  0,  64'd0, 64'd0, 1, 0)); // 8
    vt.push_back(mk(1, 5'd3,  64'h10,  5'd3,  5'd5,  0, 5'd0,  0,  64'h10,D5,    0, 0)); // 9
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd3,  5'd7,  0, 5'd0,  0,  64'h10,64'hA5,0, 0)); // 10
    vt.push_back(mk(1, 5'd9,  64'h42,  5'd9,  5'd9,  1, 5'd9,  0,  64'h42,64'h42,0, 0)); // 11
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd9,  5'd3,  0, 5'd0,  0,  64'h42,64'h10,1, 0)); // 12
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd1,  5'd2,  1, 5'd1,  0,  64'd0, 64'd0, 0, 0)); // 13
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd1,  5'd2,  1, 5'd2,  0,  64'd0, 64'd0, 1, 0)); // 14
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd2,  5'd31, 1, 5'd31, 0,  64'd0, 64'd0, 1, 0)); // 15
    vt.push_back(mk(1, 5'd1,  64'h77,  5'd31, 5'd4,  1, 5'd4,  1,  64'd0, 64'd0, 1, 0)); // 16
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd1,  5'd4,  0, 5'd0,  0,  64'h77,64'd0, 0, 0)); // 17
    vt.push_back(mk(0, 5'd0,  64'd0,   5'd9,  5'd31, 0, 5'd0,  0,  64'h42,64'd0, 0, 0)); // 18

    // Reset released mid-cycle; vector 0's write lands on the very next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      if (i > 0) @(negedge clk);
      rsd_wen = vt[i].wen; rsd_idx = vt[i].widx; rsd_data = vt[i].wdata;
      rs1_idx = vt[i].r1;  rs2_idx = vt[i].r2;
      issue_vld = vt[i].iss; issue_rd = vt[i].ird; flush = vt[i].fl;
      sbq.push_back('{id: i, ed1: vt[i].ed1, ed2: vt[i].ed2, eb1: vt[i].eb1, eb2: vt[i].eb2});
      #2;
      e = sbq.pop_front();
      chk($sformatf("v%0d_rs1_data", e.id), rs1_data, e.ed1);
      chk($sformatf("v%0d_rs2_data", e.id), rs2_data, e.ed2);
      chk($sformatf("v%0d_rs1_busy", e.id), {63'd0, rs1_busy}, {63'd0, e.eb1});
      chk($sformatf("v%0d_rs2_busy", e.id), {63'd0, rs2_busy}, {63'd0, e.eb2});
    end

    // Asynchronous reset pulse between edges wipes data and busy immediately.
    @(negedge clk); idle(); issue_vld = 1'b1; issue_rd = 5'd8;
    @(negedge clk); idle(); rs1_idx = 5'd8; rs2_idx = 5'd7;
    #1;
    chk("pre_rst_busy8", {63'd0, rs1_busy}, 64'd1);
    chk("pre_rst_x7", rs2_data, 64'hA5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy8", {63'd0, rs1_busy}, 64'd0);
    chk("async_rst_x7", rs2_data, 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    rsd_wen = 1'b1; rsd_idx = 5'd6; rsd_data = 64'h99;
    @(negedge clk); idle(); rs1_idx = 5'd6; rs2_idx = 5'd5;
    #2;
    chk("post_rst_x6", rs1_data, 64'h99);
    chk("post_rst_x5", rs2_data, 64'd0);

    // Forwarding vs. no forwarding, same stimulus on both instances.
    @(negedge clk); idle();
    rsd_wen = 1'b1; rsd_idx = 5'd12; rsd_data = 64'h5A; rs1_idx = 5'd12;
    #2;
    chk("byp_x12_data", rs1_data, 64'h5A);
    chk("nobyp_x12_data", nb_rs1_data, 64'd0);
    @(negedge clk); idle(); issue_vld = 1'b1; issue_rd = 5'd12;
    @(negedge clk); idle();
    rsd_wen = 1'b1; rsd_idx = 5'd12; rsd_data = 64'h6B; rs1_idx = 5'd12;
    #2;
    chk("byp_x12_busy", {63'd0, rs1_busy}, 64'd0);
    chk("byp_x12_fwd", rs1_data, 64'h6B);
    chk("nobyp_x12_busy", {63'd0, nb_rs1_busy}, 64'd1);
    chk("nobyp_x12_old", nb_rs1_data, 64'h5A);
    @(negedge clk); idle();
    #2;
    chk("nobyp_x12_new", nb_rs1_data, 64'h6B);
    chk("nobyp_x12_clr", {63'd0, nb_rs1_busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
